// File: rtl/elevator_dispatcher_pkg.sv
// Shared definitions for the elevator dispatcher and the car state machine:
// floor sizing, state encoding, direction constants and floor mask helpers.
package elevator_dispatcher_pkg;

  localparam int FLOOR_W    = 2;
  localparam int NUM_FLOORS = 4;

  typedef logic [FLOOR_W-1:0]    floor_t;
  typedef logic [NUM_FLOORS-1:0] floor_mask_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_MOVE_UP   = 2'b01,
    ST_MOVE_DOWN = 2'b10,
    ST_DOOR      = 2'b11
  } state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // One-hot bit for a single floor
  function automatic floor_mask_t floor_onehot(input floor_t f);
    floor_mask_t m;
    m    = '0;
    m[f] = 1'b1;
    return m;
  endfunction

  // Every floor strictly above f
  function automatic floor_mask_t above_mask(input floor_t f);
    floor_mask_t m;
    for (int i = 0; i < NUM_FLOORS; i++) m[i] = (i > int'(f));
    return m;
  endfunction

  // Every floor strictly below f
  function automatic floor_mask_t below_mask(input floor_t f);
    floor_mask_t m;
    for (int i = 0; i < NUM_FLOORS; i++) m[i] = (i < int'(f));
    return m;
  endfunction

endpackage

// File: rtl/elevator_dispatcher_dwell_timer.sv
// Door dwell down-counter. A load (or a held hold) reloads DWELL_CYCLES-1;
// otherwise it counts down to zero and sits there. expired means count is 0,
// so a freshly loaded count expires DWELL_CYCLES cycles after the load.
module dwell_timer #(
  parameter int DWELL_CYCLES = 50_000_000,
  parameter int CNT_W        = 26
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic load,
  input  logic hold,
  output logic expired
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DWELL_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // Reload on load/hold, otherwise count down and stop at zero
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count <= '0;
    end else if (load || hold) begin
      count <= RELOAD;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/elevator_dispatcher.sv
// SCAN-policy request dispatcher for the 4-floor elevator car.
// Latches call buttons, steers the car via stop_go/up_down, times the door
// dwell and strobes delete_pos/delete_floor when a floor is served.
// Optional feature macro: DOOR_HOLD_EN adds the door_hold input, which keeps
// the door open for as long as it is asserted.
module elevator_dispatcher
  import elevator_dispatcher_pkg::*;
#(
  parameter int DWELL_CYCLES = 50_000_000,
  parameter int CNT_W        = 26
) (
  input  logic                  CLK,
  input  logic                  RST_N,
`ifdef DOOR_HOLD_EN
  input  logic                  door_hold,
`endif
  input  logic [NUM_FLOORS-1:0] call_btn,
  input  logic [FLOOR_W-1:0]    cur_floor,
  output logic                  stop_go,
  output logic                  up_down,
  output logic                  door_open,
  output logic                  delete_pos,
  output logic [FLOOR_W-1:0]    delete_floor,
  output logic [NUM_FLOORS-1:0] pending
);

  state_t      state;
  logic        dir;

  floor_mask_t here_bit;
  floor_mask_t above;
  floor_mask_t below;
  floor_mask_t clr;
  floor_mask_t call_in;
  logic        any_above;
  logic        any_below;
  logic        at_pending;
  logic        door_entry;
  logic        restart;
  logic        dwell_load;
  logic        dwell_hold;
  logic        dwell_expired;
  logic        door_done;

`ifdef DOOR_HOLD_EN
  assign dwell_hold = (state == ST_DOOR) && door_hold;
`else
  assign dwell_hold = 1'b0;
`endif

  // Request masks relative to the car, door entry and dwell restart decode
  always_comb begin
    here_bit   = floor_onehot(cur_floor);
    above      = pending & above_mask(cur_floor);
    below      = pending & below_mask(cur_floor);
    any_above  = |above;
    any_below  = |below;
    at_pending = |(pending & here_bit);
    door_entry = (state != ST_DOOR) && at_pending;
    restart    = (state == ST_DOOR) && (|(call_btn & here_bit));
    clr        = door_entry ? here_bit : '0;
    call_in    = (state == ST_DOOR) ? (call_btn & ~here_bit) : call_btn;
    dwell_load = door_entry || restart;
    door_done  = dwell_expired && !restart && !dwell_hold;
  end

  dwell_timer #(
    .DWELL_CYCLES (DWELL_CYCLES),
    .CNT_W        (CNT_W)
  ) u_dwell (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .load    (dwell_load),
    .hold    (dwell_hold),
    .expired (dwell_expired)
  );

  // Dispatch FSM with request latch and registered car/door outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state        <= ST_IDLE;
      dir          <= DIR_UP;
      stop_go      <= 1'b1;
      up_down      <= 1'b1;
      door_open    <= 1'b0;
      delete_pos   <= 1'b0;
      delete_floor <= '0;
      pending      <= '0;
    end else begin
      pending    <= (pending | call_in) & ~clr;
      delete_pos <= 1'b0;
      if (door_entry) begin
        state        <= ST_DOOR;
        stop_go      <= 1'b1;
        door_open    <= 1'b1;
        delete_pos   <= 1'b1;
        delete_floor <= cur_floor;
      end else begin
        case (state)
          ST_IDLE: begin
            if (any_above && (dir == DIR_UP || !any_below)) begin
              state   <= ST_MOVE_UP;
              dir     <= DIR_UP;
              stop_go <= 1'b0;
              up_down <= DIR_UP;
            end else if (any_below) begin
              state   <= ST_MOVE_DOWN;
              dir     <= DIR_DOWN;
              stop_go <= 1'b0;
              up_down <= DIR_DOWN;
            end
          end
          ST_MOVE_UP: begin
            if (!any_above) begin
              state   <= ST_IDLE;
              stop_go <= 1'b1;
            end
          end
          ST_MOVE_DOWN: begin
            if (!any_below) begin
              state   <= ST_IDLE;
              stop_go <= 1'b1;
            end
          end
          ST_DOOR: begin
            if (door_done) begin
              door_open <= 1'b0;
              if ((dir == DIR_UP) ? any_above : any_below) begin
                state   <= (dir == DIR_UP) ? ST_MOVE_UP : ST_MOVE_DOWN;
                stop_go <= 1'b0;
                up_down <= dir;
              end else if ((dir == DIR_UP) ? any_below : any_above) begin
                state   <= (dir == DIR_UP) ? ST_MOVE_DOWN : ST_MOVE_UP;
                dir     <= ~dir;
                stop_go <= 1'b0;
                up_down <= ~dir;
              end else begin
                state <= ST_IDLE;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_elevator_dispatcher.sv
// Scoreboard bench for elevator_dispatcher with DWELL_CYCLES = 4.
// A simple car model steps cur_floor while stop_go is low. A SCAN reference
// model predicts the order of served floors and the door-open length of each;
// a monitor checks every delete_pos strobe and door interval against it.
module tb_elevator_dispatcher;

  localparam int DWELL    = 4;
  localparam int CAR_TICK = 5;

  typedef struct {
    int floor;
    int len;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] call_btn;
  logic [1:0] cur_floor;
  logic       stop_go;
  logic       up_down;
  logic       door_open;
  logic       delete_pos;
  logic [1:0] delete_floor;
  logic [3:0] pending;
`ifdef DOOR_HOLD_EN
  logic       door_hold;
`endif

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   car_cnt     = 0;
  bit   model_dir   = 1'b1;

  elevator_dispatcher #(
    .DWELL_CYCLES (DWELL),
    .CNT_W        (4)
  ) dut (
    .CLK          (clk),
    .RST_N        (rst_n),
`ifdef DOOR_HOLD_EN
    .door_hold    (door_hold),
`endif
    .call_btn     (call_btn),
    .cur_floor    (cur_floor),
    .stop_go      (stop_go),
    .up_down      (up_down),
    .door_open    (door_open),
    .delete_pos   (delete_pos),
    .delete_floor (delete_floor),
    .pending      (pending)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Global watchdog
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance to the next falling edge and move the car if it is released
  task automatic tick();
    @(negedge clk);
    if (rst_n && !stop_go) begin
      car_cnt++;
      if (car_cnt >= CAR_TICK) begin
        car_cnt = 0;
        if (up_down && cur_floor != 2'd3) cur_floor = cur_floor + 2'd1;
        else if (!up_down && cur_floor != 2'd0) cur_floor = cur_floor - 2'd1;
      end
    end else begin
      car_cnt = 0;
    end
  endtask

  task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h required %0h", name, act, want);
    end
  endtask

  // Pulse a set of calls for one cycle
  task automatic applyStimulus(input logic [3:0] mask);
    call_btn = mask;
    tick();
    call_btn = 4'b0000;
  endtask

  task automatic doReset(input logic [1:0] floor);
    rst_n     = 1'b0;
    call_btn  = 4'b0000;
    cur_floor = floor;
    car_cnt   = 0;
`ifdef DOOR_HOLD_EN
    door_hold = 1'b0;
`endif
    exp_q.delete();
    model_dir = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  // SCAN reference: current floor first, then everything in the travel
  // direction in travel order, then everything behind in reverse order
  task automatic modelPlan(input logic [3:0] mask, input int len);
    int   ups[$];
    int   downs[$];
    int   cf;
    exp_t e;
    cf    = int'(cur_floor);
    e.len = len;
    if (mask[cf]) begin
      e.floor = cf;
      exp_q.push_back(e);
    end
    for (int f = cf + 1; f < 4; f++) if (mask[f]) ups.push_back(f);
    for (int f = cf - 1; f >= 0; f--) if (mask[f]) downs.push_back(f);
    if (model_dir) begin
      foreach (ups[i]) begin e.floor = ups[i]; exp_q.push_back(e); end
      foreach (downs[i]) begin e.floor = downs[i]; exp_q.push_back(e); end
      if (downs.size() > 0) model_dir = 1'b0;
    end else begin
      foreach (downs[i]) begin e.floor = downs[i]; exp_q.push_back(e); end
      foreach (ups[i]) begin e.floor = ups[i]; exp_q.push_back(e); end
      if (ups.size() > 0) model_dir = 1'b1;
    end
  endtask

  // Run until every expected service happened and the dispatcher is idle
  task automatic waitIdle(input string name, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (stop_go && !door_open && pending == 4'b0000 && exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("[TB] FAIL %s idle timeout: got %0d services outstanding, pending %b, required 0 outstanding",
               name, exp_q.size(), pending);
      exp_q.delete();
    end
  endtask

  task automatic waitDoor(input string name, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (door_open) begin
        seen = 1'b1;
        break;
      end
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("[TB] FAIL %s door wait: got door_open=0 required 1", name);
    end
  endtask

  // Monitor: each delete_pos pops one expected service; door length checked on close
  int door_run  = 0;
  int cur_len   = 0;
  bit len_valid = 1'b0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        door_run  = 0;
        len_valid = 1'b0;
      end else begin
        if (delete_pos) begin
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL unexpected delete_pos: got floor %0d required no strobe", delete_floor);
          end else begin
            e = exp_q.pop_front();
            if (int'(delete_floor) != e.floor) begin
              miscompares++;
              $display("[TB] FAIL delete_floor: got %0d required %0d", delete_floor, e.floor);
            end
            cur_len   = e.len;
            len_valid = 1'b1;
          end
          vectors++;
          if ({door_open, stop_go} !== 2'b11) begin
            miscompares++;
            $display("[TB] FAIL door state at strobe: got door_open=%b stop_go=%b required 1 1",
                     door_open, stop_go);
          end
        end
        if (door_open) begin
          door_run++;
        end else if (door_run != 0) begin
          if (len_valid) begin
            vectors++;
            if (door_run != cur_len) begin
              miscompares++;
              $display("[TB] FAIL door length: got %0d cycles required %0d", door_run, cur_len);
            end
          end
          door_run  = 0;
          len_valid = 1'b0;
        end
      end
    end
  end

  initial begin
    logic [3:0] mask;
    bit         arrived;
    rst_n     = 1'b0;
    call_btn  = 4'b0000;
    cur_floor = 2'd0;
`ifdef DOOR_HOLD_EN
    door_hold = 1'b0;
`endif
    #12;
    checkOutput("reset stop_go", stop_go, 1);
    checkOutput("reset up_down", up_down, 1);
    checkOutput("reset door_open", door_open, 0);
    checkOutput("reset delete_pos", delete_pos, 0);
    checkOutput("reset delete_floor", delete_floor, 0);
    checkOutput("reset pending", pending, 0);

    // Single call for floor 2 from floor 0
    doReset(2'd0);
    $display("[TB] single call floor 2 from floor 0");
    modelPlan(4'b0100, DWELL);
    applyStimulus(4'b0100);
    checkOutput("call latched pending", pending, 4'b0100);
    checkOutput("call latched stop_go still held", stop_go, 1);
    tick();
    checkOutput("depart stop_go", stop_go, 0);
    checkOutput("depart up_down", up_down, 1);
    arrived = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (cur_floor == 2'd2) begin
        arrived = 1'b1;
        break;
      end
    end
    checkOutput("car reached floor 2", {3'b000, arrived}, 1);
    tick();
    checkOutput("arrival delete_pos", delete_pos, 1);
    checkOutput("arrival stop_go", stop_go, 1);
    checkOutput("arrival door_open", door_open, 1);
    checkOutput("arrival pending cleared", pending, 0);
    waitIdle("single call", 200);

    // Moving up from floor 1 toward 3, then a call for floor 0
    doReset(2'd1);
    $display("[TB] up toward 3 with late call for 0");
    modelPlan(4'b1001, DWELL);
    applyStimulus(4'b1000);
    tick();
    checkOutput("moving up stop_go", stop_go, 0);
    applyStimulus(4'b0001);
    waitDoor("floor 3 service", 200);
    for (int i = 0; i < 50 && door_open; i++) tick();
    checkOutput("reversal stop_go", stop_go, 0);
    checkOutput("reversal up_down", up_down, 0);
    waitIdle("reversal", 300);

    // Same-floor call during dwell restarts it with a single strobe
    doReset(2'd2);
    $display("[TB] same-floor restart during dwell");
    modelPlan(4'b0100, 2 + DWELL);
    applyStimulus(4'b0100);
    waitDoor("restart door", 10);
    checkOutput("restart stop_go held", stop_go, 1);
    tick();
    call_btn = 4'b0100;
    tick();
    call_btn = 4'b0000;
    checkOutput("restart call not latched", pending, 0);
    waitIdle("restart", 100);

    // All four floors from floor 0
    doReset(2'd0);
    $display("[TB] all floors from floor 0");
    modelPlan(4'b1111, DWELL);
    applyStimulus(4'b1111);
    waitIdle("all floors", 400);

`ifdef DOOR_HOLD_EN
    // Door held open for 10 cycles
    doReset(2'd1);
    $display("[TB] door hold");
    modelPlan(4'b0010, 10 + DWELL);
    applyStimulus(4'b0010);
    waitDoor("hold door", 10);
    door_hold = 1'b1;
    repeat (10) tick();
    door_hold = 1'b0;
    checkOutput("hold door_open", door_open, 1);
    waitIdle("hold", 100);
`endif

    // Random call sets served from wherever the car ends up
    doReset(2'($urandom_range(0, 3)));
    for (int n = 0; n < 12; n++) begin
      mask = 4'($urandom_range(1, 15));
      $display("[TB] random scenario %0d: floor %0d calls %b", n, cur_floor, mask);
      modelPlan(mask, DWELL);
      applyStimulus(mask);
      waitIdle("random", 600);
    end

    // Asynchronous reset while moving down
    doReset(2'd3);
    $display("[TB] reset during downward move");
    applyStimulus(4'b0001);
    tick();
    checkOutput("pre-reset stop_go", stop_go, 0);
    checkOutput("pre-reset up_down", up_down, 0);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset stop_go", stop_go, 1);
    checkOutput("async reset up_down", up_down, 1);
    checkOutput("async reset pending", pending, 0);
    checkOutput("async reset door_open", door_open, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
